// File: rtl/cache_ctrl_dm.sv
// cache_ctrl_dm: direct-mapped, write-through, no-write-allocate cache controller.
// Drives an external async-read / sync-write line array ({valid, tag, data} per line),
// serves a Wishbone classic slave port and issues misses and writes on a Wishbone master port.
// The array is swept invalid after reset and on flush_i.
// Optional feature macro: CACHE_STATS_EN adds the hit_cnt_o / miss_cnt_o read statistics.
module cache_ctrl_dm #(
  parameter  int AWIDTH = 30,
  parameter  int DWIDTH = 32,
  parameter  int IDX_W  = 10,
  localparam int TAG_W  = AWIDTH - IDX_W,
  localparam int LINE_W = 1 + TAG_W + DWIDTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // CPU-side Wishbone slave
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] adr_i,
  input  logic [DWIDTH-1:0] dat_i,
  output logic [DWIDTH-1:0] dat_o,
  output logic              ack_o,
  input  logic              flush_i,
  output logic              busy_o,
  // memory-side Wishbone master
  output logic              mem_cyc_o,
  output logic              mem_stb_o,
  output logic              mem_we_o,
  output logic [AWIDTH-1:0] mem_adr_o,
  output logic [DWIDTH-1:0] mem_dat_o,
  input  logic [DWIDTH-1:0] mem_dat_i,
  input  logic              mem_ack_i,
  // line array
  output logic              cache_we_o,
  output logic [IDX_W-1:0]  cache_adr_o,
  output logic [LINE_W-1:0] cache_dat_o,
  input  logic [LINE_W-1:0] cache_dat_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_ACK
  } state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [DWIDTH-1:0]   dat_q, dat_d;
  logic                mem_cyc_q, mem_cyc_d;
  logic                mem_we_q, mem_we_d;
  logic [AWIDTH-1:0]   mem_adr_q, mem_adr_d;
  logic [DWIDTH-1:0]   mem_dat_q, mem_dat_d;
  logic                abort_q, abort_d;   // CPU abandoned the cycle; finish it silently

  logic                req;
  logic                in_mem;
  logic [AWIDTH-1:0]   lk_adr;
  logic                line_valid;
  logic [TAG_W-1:0]    line_tag;
  logic [DWIDTH-1:0]   line_data;
  logic                hit;

  assign req    = cyc_i & stb_i;
  assign in_mem = (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

  // Memory phases look up with the latched address so a fill or update still lands
  // on the right line if the CPU walks away mid-transaction.
  assign lk_adr     = in_mem ? mem_adr_q : adr_i;
  assign line_valid = cache_dat_i[LINE_W-1];
  assign line_tag   = cache_dat_i[LINE_W-2 -: TAG_W];
  assign line_data  = cache_dat_i[DWIDTH-1:0];
  assign hit        = line_valid && (line_tag == lk_adr[AWIDTH-1:IDX_W]);

  // State and datapath registers
  // NOTE: sequential state uses non-blocking assignments only, so every flop samples
  // the pre-edge value of every other flop regardless of process evaluation order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_FLUSH;
      cnt_q     <= '0;
      dat_q     <= '0;
      mem_cyc_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_adr_q <= '0;
      mem_dat_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dat_q     <= dat_d;
      mem_cyc_q <= mem_cyc_d;
      mem_we_q  <= mem_we_d;
      mem_adr_q <= mem_adr_d;
      mem_dat_q <= mem_dat_d;
      abort_q   <= abort_d;
    end
  end

  // Next-state logic
  // NOTE: every variable assigned in an always_comb gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FLUSH:  if (cnt_q == '1) state_d = ST_IDLE;
      ST_IDLE: begin
        if (flush_i)   state_d = ST_FLUSH;
        else if (req)  state_d = we_i ? ST_MEM_WR : (hit ? ST_ACK : ST_MEM_RD);
      end
      ST_MEM_RD: if (mem_ack_i) state_d = ST_ACK;
      ST_MEM_WR: if (mem_ack_i) state_d = ST_ACK;
      ST_ACK:    state_d = ST_IDLE;
      default:   state_d = ST_FLUSH;
    endcase
  end

  // Datapath next values: sweep counter, read data, memory request and abort tracking
  always_comb begin
    cnt_d     = cnt_q;
    dat_d     = dat_q;
    mem_cyc_d = mem_cyc_q;
    mem_we_d  = mem_we_q;
    mem_adr_d = mem_adr_q;
    mem_dat_d = mem_dat_q;
    abort_d   = abort_q;
    unique case (state_q)
      ST_FLUSH: cnt_d = cnt_q + 1'b1;
      ST_IDLE: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        if (!flush_i && req) begin
          mem_adr_d = adr_i;
          mem_we_d  = we_i;
          mem_cyc_d = we_i | ~hit;
          if (we_i)      mem_dat_d = dat_i;
          else if (hit)  dat_d     = line_data;
        end
      end
      ST_MEM_RD: begin
        if (!req) abort_d = 1'b1;
        if (mem_ack_i) begin
          mem_cyc_d = 1'b0;
          dat_d     = mem_dat_i;
        end
      end
      ST_MEM_WR: begin
        if (!req) abort_d = 1'b1;
        if (mem_ack_i) begin
          mem_cyc_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Outputs: array port, CPU ack and busy flag
  always_comb begin
    cache_we_o  = 1'b0;
    cache_adr_o = lk_adr[IDX_W-1:0];
    cache_dat_o = '0;
    ack_o       = 1'b0;
    busy_o      = 1'b0;
    unique case (state_q)
      ST_FLUSH: begin
        busy_o      = 1'b1;
        cache_adr_o = cnt_q;
        // The reset state is FLUSH; hold the array write off while reset is asserted.
        cache_we_o  = rst_ni;
      end
      ST_MEM_RD: begin
        if (mem_ack_i) begin
          cache_we_o  = 1'b1;
          cache_dat_o = {1'b1, mem_adr_q[AWIDTH-1:IDX_W], mem_dat_i};
        end
      end
      ST_MEM_WR: begin
        // No write-allocate: only a line already holding this address is refreshed.
        if (mem_ack_i && hit) begin
          cache_we_o  = 1'b1;
          cache_dat_o = {1'b1, mem_adr_q[AWIDTH-1:IDX_W], mem_dat_q};
        end
      end
      ST_ACK: ack_o = req & ~abort_q;
      default: ;
    endcase
  end

  assign dat_o     = dat_q;
  assign mem_cyc_o = mem_cyc_q;
  assign mem_stb_o = mem_cyc_q;
  assign mem_we_o  = mem_we_q;
  assign mem_adr_o = mem_adr_q;
  assign mem_dat_o = mem_dat_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Read hit/miss statistics, counted at the IDLE decision and cleared on flush entry
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == ST_IDLE) begin
      if (flush_i) begin
        hit_cnt_d  = '0;
        miss_cnt_d = '0;
      end else if (req && !we_i) begin
        if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
        else     miss_cnt_d = miss_cnt_q + 32'd1;
      end
    end
  end

  // Statistics registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// tb_cache_ctrl_dm: self-checking bench for cache_ctrl_dm with a behavioural line array,
// a 3-cycle-latency memory slave and a scoreboard queue of expected read data.
module tb_cache_ctrl_dm;

  localparam int AWIDTH = 30;
  localparam int DWIDTH = 32;
  localparam int IDX_W  = 10;
  localparam int TAG_W  = AWIDTH - IDX_W;
  localparam int LINE_W = 1 + TAG_W + DWIDTH;
  localparam int DEPTH  = 1 << IDX_W;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              cyc_i, stb_i, we_i, flush_i;
  logic [AWIDTH-1:0] adr_i;
  logic [DWIDTH-1:0] dat_i, dat_o;
  logic              ack_o, busy_o;
  logic              mem_cyc_o, mem_stb_o, mem_we_o, mem_ack_i;
  logic [AWIDTH-1:0] mem_adr_o;
  logic [DWIDTH-1:0] mem_dat_o, mem_dat_i;
  logic              cache_we_o;
  logic [IDX_W-1:0]  cache_adr_o;
  logic [LINE_W-1:0] cache_dat_o, cache_dat_i;
`ifdef CACHE_STATS_EN
  logic [31:0]       hit_cnt_o, miss_cnt_o;
`endif

  cache_ctrl_dm #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .IDX_W(IDX_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i), .adr_i(adr_i), .dat_i(dat_i),
    .dat_o(dat_o), .ack_o(ack_o), .flush_i(flush_i), .busy_o(busy_o),
    .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o), .mem_we_o(mem_we_o),
    .mem_adr_o(mem_adr_o), .mem_dat_o(mem_dat_o), .mem_dat_i(mem_dat_i), .mem_ack_i(mem_ack_i),
    .cache_we_o(cache_we_o), .cache_adr_o(cache_adr_o), .cache_dat_o(cache_dat_o),
    .cache_dat_i(cache_dat_i)
`ifdef CACHE_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;
  int exp_hit = 0;
  int exp_miss = 0;
  logic [DWIDTH-1:0] exp_q[$];

  // Behavioural line array: async read, sync write, optional all-ones preload
  logic [LINE_W-1:0] cache_arr [0:DEPTH-1];
  logic              preload = 1'b0;
  assign cache_dat_i = cache_arr[cache_adr_o];
  always @(posedge clk_i) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) cache_arr[i] <= '1;
    end else if (cache_we_o) begin
      cache_arr[cache_adr_o] <= cache_dat_o;
    end
  end

  // Backing memory: written locations in an associative store, others a fixed pattern
  logic [DWIDTH-1:0] mem_store [int];
  logic [AWIDTH-1:0] log_adr;
  logic              log_we;
  int                mem_wait;

  function automatic logic [DWIDTH-1:0] mem_val(input logic [AWIDTH-1:0] a);
    if (mem_store.exists(int'(a))) return mem_store[int'(a)];
    return {2'b00, a} ^ 32'h5A5A_0000;
  endfunction

  // Memory slave: acks on the third cycle of a held request
  initial begin
    mem_ack_i = 1'b0;
    mem_dat_i = '0;
    mem_wait  = 0;
    log_adr   = '0;
    log_we    = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni || mem_ack_i) begin
        mem_ack_i = 1'b0;
        mem_wait  = 0;
      end else if (mem_cyc_o && mem_stb_o) begin
        mem_wait++;
        if (mem_wait == 3) begin
          mem_ack_i = 1'b1;
          log_adr   = mem_adr_o;
          log_we    = mem_we_o;
          if (mem_we_o) mem_store[int'(mem_adr_o)] = mem_dat_o;
          else          mem_dat_i = mem_val(mem_adr_o);
        end
      end else begin
        mem_wait = 0;
      end
    end
  end

  function automatic logic [LINE_W-1:0] line_of(input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
    return {1'b1, a[AWIDTH-1:IDX_W], d};
  endfunction

  // Counts busy cycles from the current negedge and checks the sweep length and result
  task automatic check_sweep(input string nm);
    int cnt;
    int nonzero;
    cnt = 0;
    while (busy_o && cnt < 2000) begin
      @(negedge clk_i);
      cnt++;
    end
    n_vec++;
    if (cnt != DEPTH) begin
      n_err++;
      $display("FAIL %s_busy_cycles: got %0d, expected %0d", nm, cnt, DEPTH);
    end
    nonzero = 0;
    for (int i = 0; i < DEPTH; i++) if (cache_arr[i] !== '0) nonzero++;
    n_vec++;
    if (nonzero != 0) begin
      n_err++;
      $display("FAIL %s_lines_cleared: got %0d non-zero lines, expected 0", nm, nonzero);
    end
  endtask

  // One CPU transaction; reads push their expected data and pop it on ack_o
  task automatic cpu_op(input logic w, input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d,
                        input logic exp_mem, input logic [DWIDTH-1:0] exp_d, input string nm);
    int   cyc_cnt;
    logic mem_seen, got_ack;
    logic [DWIDTH-1:0] exp_pop;
    if (!w) begin
      exp_q.push_back(exp_d);
      if (exp_mem) exp_miss++;
      else         exp_hit++;
    end
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = w; adr_i = a; dat_i = d;
    mem_seen = 1'b0; got_ack = 1'b0; cyc_cnt = 0;
    while (!got_ack && cyc_cnt < 100) begin
      @(posedge clk_i); #1;
      cyc_cnt++;
      if (mem_cyc_o) mem_seen = 1'b1;
      if (ack_o)     got_ack  = 1'b1;
    end
    n_vec++;
    if (!got_ack) begin
      n_err++;
      $display("FAIL %s_ack: got no ack_o, expected one within 100 cycles", nm);
      if (!w) exp_pop = exp_q.pop_front();
    end else if (!w) begin
      exp_pop = exp_q.pop_front();
      n_vec++;
      if (dat_o !== exp_pop) begin
        n_err++;
        $display("FAIL %s_data: got %h, expected %h", nm, dat_o, exp_pop);
      end
    end
    n_vec++;
    if (mem_seen !== exp_mem) begin
      n_err++;
      $display("FAIL %s_mem_access: got %b, expected %b", nm, mem_seen, exp_mem);
    end
    if (exp_mem && mem_seen) begin
      n_vec++;
      if (log_adr !== a || log_we !== w) begin
        n_err++;
        $display("FAIL %s_mem_cmd: got adr %h we %b, expected adr %h we %b", nm, log_adr, log_we, a, w);
      end
    end
    if (!w && !exp_mem && got_ack) begin
      n_vec++;
      if (cyc_cnt != 1) begin
        n_err++;
        $display("FAIL %s_hit_latency: got %0d cycles, expected 1", nm, cyc_cnt);
      end
    end
    @(negedge clk_i);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [99:0] got, exp;
    rst_ni = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; flush_i = 1'b0;
    adr_i = '0; dat_i = '0;
    preload = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    preload = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    got = {ack_o, dat_o, mem_cyc_o, mem_stb_o, mem_we_o, mem_adr_o, mem_dat_o, cache_we_o, busy_o};
    exp = {1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 1'b0, 1'b1};
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_values: got %h, expected %h", got, exp);
    end
    rst_ni = 1'b1;
    check_sweep("reset");
    exp_hit = 0; exp_miss = 0;
  endtask

  task automatic test_read_fill();
    mem_store[int'(30'h100)] = 32'hDEAD_BEEF;
    cpu_op(1'b0, 30'h100, '0, 1'b1, 32'hDEAD_BEEF, "rd_miss_100");
    cpu_op(1'b0, 30'h100, '0, 1'b0, 32'hDEAD_BEEF, "rd_hit_100");
  endtask

  task automatic test_write_hit();
    cpu_op(1'b1, 30'h100, 32'h1234_5678, 1'b1, '0, "wr_hit_100");
    n_vec++;
    if (cache_arr[10'h100] !== line_of(30'h100, 32'h1234_5678)) begin
      n_err++;
      $display("FAIL wr_hit_line: got %h, expected %h", cache_arr[10'h100], line_of(30'h100, 32'h1234_5678));
    end
    n_vec++;
    if (mem_val(30'h100) !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL wr_hit_mem: got %h, expected 12345678", mem_val(30'h100));
    end
    cpu_op(1'b0, 30'h100, '0, 1'b0, 32'h1234_5678, "rd_after_wr_100");
  endtask

  task automatic test_write_miss();
    cpu_op(1'b1, 30'h200, 32'hCAFE_F00D, 1'b1, '0, "wr_miss_200");
    n_vec++;
    if (cache_arr[10'h200] !== '0) begin
      n_err++;
      $display("FAIL wr_miss_no_alloc: got %h, expected 0", cache_arr[10'h200]);
    end
    cpu_op(1'b0, 30'h200, '0, 1'b1, 32'hCAFE_F00D, "rd_miss_200");
  endtask

  task automatic test_evict();
    cpu_op(1'b0, 30'h500, '0, 1'b1, mem_val(30'h500), "rd_evict_500");
    cpu_op(1'b0, 30'h100, '0, 1'b1, 32'h1234_5678, "rd_evicted_100");
  endtask

  task automatic test_back_to_back();
    int   gap;
    logic seen;
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'hCAFE_F00D);
    exp_hit += 2;
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 30'h100;
    for (int k = 0; k < 2; k++) begin
      gap = 0; seen = 1'b0;
      while (!seen && gap < 20) begin
        @(posedge clk_i); #1;
        gap++;
        if (ack_o) seen = 1'b1;
      end
      n_vec++;
      if (gap != (k == 0 ? 1 : 2) || !seen) begin
        n_err++;
        $display("FAIL b2b_gap_%0d: got %0d cycles ack %b, expected %0d cycles", k, gap, seen, (k == 0 ? 1 : 2));
      end
      n_vec++;
      if (dat_o !== exp_q[0]) begin
        n_err++;
        $display("FAIL b2b_data_%0d: got %h, expected %h", k, dat_o, exp_q[0]);
      end
      void'(exp_q.pop_front());
      @(negedge clk_i);
      adr_i = 30'h200;
    end
    cyc_i = 1'b0; stb_i = 1'b0;
  endtask

  task automatic test_flush();
`ifdef CACHE_STATS_EN
    n_vec++;
    if (hit_cnt_o !== 32'(exp_hit) || miss_cnt_o !== 32'(exp_miss)) begin
      n_err++;
      $display("FAIL stats_before_flush: got %0d/%0d, expected %0d/%0d", hit_cnt_o, miss_cnt_o, exp_hit, exp_miss);
    end
`endif
    @(negedge clk_i);
    flush_i = 1'b1;
    @(negedge clk_i);
    flush_i = 1'b0;
    check_sweep("flush");
    exp_hit = 0; exp_miss = 0;
`ifdef CACHE_STATS_EN
    n_vec++;
    if (hit_cnt_o !== 32'd0 || miss_cnt_o !== 32'd0) begin
      n_err++;
      $display("FAIL stats_after_flush: got %0d/%0d, expected 0/0", hit_cnt_o, miss_cnt_o);
    end
`endif
    cpu_op(1'b0, 30'h100, '0, 1'b1, 32'h1234_5678, "rd_flushed_100");
    cpu_op(1'b0, 30'h200, '0, 1'b1, 32'hCAFE_F00D, "rd_flushed_200");
  endtask

  task automatic test_abort();
    int   cnt;
    logic ack_seen;
    exp_miss++;
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b0; adr_i = 30'h300;
    cnt = 0;
    while (!mem_cyc_o && cnt < 20) begin
      @(posedge clk_i); #1;
      cnt++;
    end
    @(negedge clk_i);
    cyc_i = 1'b0; stb_i = 1'b0;
    ack_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      if (ack_o) ack_seen = 1'b1;
    end
    n_vec++;
    if (ack_seen !== 1'b0 || mem_cyc_o !== 1'b0) begin
      n_err++;
      $display("FAIL abort_ack: got ack %b mem_cyc %b, expected 0 0", ack_seen, mem_cyc_o);
    end
    n_vec++;
    if (cache_arr[10'h300] !== line_of(30'h300, mem_val(30'h300))) begin
      n_err++;
      $display("FAIL abort_fill: got %h, expected %h", cache_arr[10'h300], line_of(30'h300, mem_val(30'h300)));
    end
    cpu_op(1'b0, 30'h300, '0, 1'b0, mem_val(30'h300), "rd_after_abort_300");
`ifdef CACHE_STATS_EN
    n_vec++;
    if (hit_cnt_o !== 32'(exp_hit) || miss_cnt_o !== 32'(exp_miss)) begin
      n_err++;
      $display("FAIL stats_counts: got %0d/%0d, expected %0d/%0d", hit_cnt_o, miss_cnt_o, exp_hit, exp_miss);
    end
`endif
  endtask

  task automatic test_reset_mid_write();
    int cnt;
    @(negedge clk_i);
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; adr_i = 30'h123; dat_i = 32'h0BAD_CAFE;
    cnt = 0;
    while (!mem_cyc_o && cnt < 20) begin
      @(posedge clk_i); #1;
      cnt++;
    end
    n_vec++;
    if (mem_cyc_o !== 1'b1 || mem_we_o !== 1'b1) begin
      n_err++;
      $display("FAIL midwr_started: got cyc %b we %b, expected 1 1", mem_cyc_o, mem_we_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if (mem_cyc_o !== 1'b0 || mem_stb_o !== 1'b0 || busy_o !== 1'b1) begin
      n_err++;
      $display("FAIL midwr_reset: got cyc %b stb %b busy %b, expected 0 0 1", mem_cyc_o, mem_stb_o, busy_o);
    end
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    check_sweep("midwr");
    exp_hit = 0; exp_miss = 0;
    cpu_op(1'b0, 30'h300, '0, 1'b1, mem_val(30'h300), "rd_after_reset_300");
  endtask

  initial begin
    test_reset();
    test_read_fill();
    test_write_hit();
    test_write_miss();
    test_evict();
    test_back_to_back();
    test_flush();
    test_abort();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
